wb_arbiter: RTL

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_pkg.sv | 13 +
 rtl/wb_arb_pick.sv | 18 +
 rtl/wb_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared grant-state enum and outstanding-counter constants for the Wishbone arbiter
package wb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_M0 = 2'd1,
    GNT_M1 = 2'd2
  } gnt_state_e;

  localparam int CNT_W = 3;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/wb_arb_pick.sv
// rtl/wb_arb_pick.sv - combinational winner select; round-robin when WB_ARBITER_RR_EN, else m1 priority
module wb_arb_pick (
  input  logic req0,
  input  logic req1,
  input  logic last_m1,
  output logic win_m1
);

`ifdef WB_ARBITER_RR_EN
  // On a tie the master that did not hold the bus most recently wins.
  assign win_m1 = req1 & (~req0 | ~last_m1);
`else
  logic unused_last;
  assign unused_last = last_m1;
  assign win_m1      = req1;
`endif

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - two-master pipelined Wishbone B4 arbiter (optional macro WB_ARBITER_RR_EN)
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic            m0_we_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic [DW-1:0]   m0_dat_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_stall_o,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic            m1_we_i,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic [DW-1:0]   m1_dat_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_stall_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic [DW-1:0]   s_dat_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  input  logic            s_stall_i
);

  gnt_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_m1;
  logic             win_m1;
  logic             busy, full, acc, ack_v, cur_cyc, oth_cyc, release_gnt;

  assign busy  = (cnt_q != '0);
  assign full  = (cnt_q == CNT_MAX);
  assign acc   = s_stb_o & ~s_stall_i;
  // Acks with nothing outstanding are stray and are dropped entirely.
  assign ack_v = s_ack_i & busy;
  assign cnt_d = cnt_q + CNT_W'(acc) - CNT_W'(ack_v);

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  wb_arb_pick u_pick (
    .req0    (m0_cyc_i),
    .req1    (m1_cyc_i),
    .last_m1 (last_m1),
    .win_m1  (win_m1)
  );

`ifdef WB_ARBITER_RR_EN
  logic last_q;
  assign last_m1 = last_q;
`else
  assign last_m1 = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
`ifdef WB_ARBITER_RR_EN
      last_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
`ifdef WB_ARBITER_RR_EN
      if (state_d == GNT_M1) last_q <= 1'b1;
      else if (state_d == GNT_M0) last_q <= 1'b0;
`endif
    end
  end

  always_comb begin
    cur_cyc = 1'b0;
    oth_cyc = 1'b0;
    if (state_q == GNT_M0) begin
      cur_cyc = m0_cyc_i;
      oth_cyc = m1_cyc_i;
    end else if (state_q == GNT_M1) begin
      cur_cyc = m1_cyc_i;
      oth_cyc = m0_cyc_i;
    end
    // The last outstanding ack retiring this cycle counts as already drained.
    release_gnt = ~cur_cyc & (~busy | ((cnt_q == CNT_W'(1)) & ack_v & ~acc));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (m0_cyc_i | m1_cyc_i) state_d = win_m1 ? GNT_M1 : GNT_M0;
      end
      GNT_M0: begin
        if (release_gnt) state_d = oth_cyc ? GNT_M1 : IDLE;
      end
      GNT_M1: begin
        if (release_gnt) state_d = oth_cyc ? GNT_M0 : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_cyc_o    = 1'b0;
    s_stb_o    = 1'b0;
    s_we_o     = 1'b0;
    s_adr_o    = '0;
    s_sel_o    = '0;
    s_dat_o    = '0;
    m0_ack_o   = 1'b0;
    m1_ack_o   = 1'b0;
    m0_stall_o = 1'b1;
    m1_stall_o = 1'b1;
    case (state_q)
      GNT_M0: begin
        s_cyc_o    = m0_cyc_i | busy;
        s_stb_o    = m0_cyc_i & m0_stb_i & ~full;
        s_we_o     = m0_we_i;
        s_adr_o    = m0_adr_i;
        s_sel_o    = m0_sel_i;
        s_dat_o    = m0_dat_i;
        m0_ack_o   = ack_v;
        m0_stall_o = s_stall_i | full;
      end
      GNT_M1: begin
        s_cyc_o    = m1_cyc_i | busy;
        s_stb_o    = m1_cyc_i & m1_stb_i & ~full;
        s_we_o     = m1_we_i;
        s_adr_o    = m1_adr_i;
        s_sel_o    = m1_sel_i;
        s_dat_o    = m1_dat_i;
        m1_ack_o   = ack_v;
        m1_stall_o = s_stall_i | full;
      end
      default: ;
    endcase
  end

endmodule
